// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Round-robin scheduler sharing one byte-level UART transmitter between
// NREQ requesters. The granted requester streams its payload into a
// 256-byte packet buffer. The block then sends the packet as
// checksum, address, length, payload. The checksum makes the 8-bit sum of
// all packet bytes equal zero.
//
// Ports:
//   clk       system clock, rising edge
//   RESET_N   asynchronous active-low reset
//   req       per-requester packet request (held until its grant rises)
//   req_addr  packed destination addresses, slice i = [8*i+7:8*i]
//   req_len   packed payload lengths, 1..255, 0 means 256
//   wr_data   packed payload bytes
//   wr_valid  payload strobes, only the owner's is used during LOAD
//   grant     one-hot, high from grant through the end of LOAD
//   done      one-cycle pulse to the owner after its last byte is sent
//   tx_data   byte to the transmitter
//   tx_send   one-cycle send pulse to the transmitter
//   tx_busy   transmitter busy (registered, rises the cycle after tx_send)
//   busy      high whenever the scheduler is not idle
module uart_tx_sched #(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_len,
  input  logic [8*NREQ-1:0] wr_data,
  input  logic [NREQ-1:0]   wr_valid,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  input  logic              tx_busy,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND_CK, S_SEND_ADDR, S_SEND_LEN, S_SEND_DATA, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      ptr_q, ptr_d;    // write pointer in LOAD, read index in SEND_DATA
  logic            guard_q, guard_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;

  logic [7:0]      pkt_buf [256];

  logic            found;
  logic [IW-1:0]   pick;
  logic [7:0]      own_data;
  logic            own_valid;
  logic            wr_en;
  logic            in_send;
  logic [7:0]      send_byte;
  logic            send_fire;

  // First requesting index at or after rr_ptr, searching upward with wrap.
  always_comb begin
    // NOTE: every variable gets a default before any branch; otherwise a
    // path that skips the assignment infers a latch.
    found = 1'b0;
    pick  = rr_ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(rr_ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        pick  = IW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  assign own_data  = wr_data[8*int'(owner_q) +: 8];
  assign own_valid = wr_valid[owner_q];
  assign wr_en     = (state_q == S_LOAD) && own_valid;

  // Byte presented in each send state; tx_data idles at zero elsewhere.
  always_comb begin
    in_send   = 1'b0;
    send_byte = 8'h00;
    case (state_q)
      S_SEND_CK:   begin in_send = 1'b1; send_byte = 8'h00 - sum_q;   end
      S_SEND_ADDR: begin in_send = 1'b1; send_byte = addr_q;          end
      S_SEND_LEN:  begin in_send = 1'b1; send_byte = len_q;           end
      S_SEND_DATA: begin in_send = 1'b1; send_byte = pkt_buf[ptr_q];  end
      default:     ;
    endcase
  end

  // The guard blocks the cycle right after a pulse, before tx_busy has risen.
  assign send_fire = in_send && !tx_busy && !guard_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    len_d    = len_q;
    sum_d    = sum_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    done_d   = '0;
    guard_d  = send_fire;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d        = pick;
          addr_d         = req_addr[8*int'(pick) +: 8];
          len_d          = req_len[8*int'(pick) +: 8];
          sum_d          = req_addr[8*int'(pick) +: 8] + req_len[8*int'(pick) +: 8];
          ptr_d          = 8'h00;
          grant_d        = '0;
          grant_d[pick]  = 1'b1;
          state_d        = S_LOAD;
        end
      end
      S_LOAD: begin
        if (own_valid) begin
          sum_d = sum_q + own_data;
          ptr_d = ptr_q + 8'd1;
          // len-1 is 255 for len=0, so the 256-byte case ends on the wrap.
          if (ptr_q == len_q - 8'd1) begin
            ptr_d   = 8'h00;
            grant_d = '0;
            state_d = S_SEND_CK;
          end
        end
      end
      S_SEND_CK:   if (send_fire) state_d = S_SEND_ADDR;
      S_SEND_ADDR: if (send_fire) state_d = S_SEND_LEN;
      S_SEND_LEN:  if (send_fire) state_d = S_SEND_DATA;
      S_SEND_DATA: begin
        if (send_fire) begin
          ptr_d = ptr_q + 8'd1;
          if (ptr_q == len_q - 8'd1) begin
            done_d[owner_q] = 1'b1;
            state_d         = S_DONE;
          end
        end
      end
      S_DONE: begin
        rr_ptr_d = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      addr_q   <= 8'h00;
      len_q    <= 8'h00;
      sum_q    <= 8'h00;
      ptr_q    <= 8'h00;
      guard_q  <= 1'b0;
      grant_q  <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      sum_q    <= sum_d;
      ptr_q    <= ptr_d;
      guard_q  <= guard_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
    end
  end

  // NOTE: the buffer has no reset; every byte is written before it is read,
  // and leaving it out lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) pkt_buf[ptr_q] <= own_data;
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign tx_send = send_fire;
  assign tx_data = send_byte;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with two requesters and a
// behavioural transmitter whose busy time is set per test.
module tb_uart_tx_sched;

  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              RESET_N = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] req_addr = '0;
  logic [8*NREQ-1:0] req_len = '0;
  logic [8*NREQ-1:0] wr_data = '0;
  logic [NREQ-1:0]   wr_valid = '0;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [7:0]        tx_data;
  logic              tx_send;
  logic              tx_busy;
  logic              busy;

  uart_tx_sched #(.NREQ(NREQ)) dut (
    .clk      (clk),
    .RESET_N  (RESET_N),
    .req      (req),
    .req_addr (req_addr),
    .req_len  (req_len),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .grant    (grant),
    .done     (done),
    .tx_data  (tx_data),
    .tx_send  (tx_send),
    .tx_busy  (tx_busy),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter model: busy for busy_len cycles starting the cycle after a send.
  // It is not reset, so a byte in flight finishes on the line.
  int busy_len = 0;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_send) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Monitor on the falling edge: captures sent bytes and checks the
  // handshake and grant invariants.
  logic [7:0] rx_q[$];
  int cyc = 0;
  int last_send = -10;
  int done_cnt [NREQ];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (tx_send) begin
      rx_q.push_back(tx_data);
      check("send_while_busy", 32'(tx_busy), 32'd0);
      check("send_spacing", 32'((cyc - last_send) >= 2), 32'd1);
      last_send = cyc;
    end
    if (grant != '0) check("grant_onehot", 32'($onehot(grant)), 32'd1);
    for (int i = 0; i < NREQ; i++) if (done[i]) done_cnt[i]++;
  end

  typedef struct {
    int         owner;
    logic [7:0] addr;
    logic [7:0] len;
    logic [7:0] d0;    // payload byte i is d0+i
    int         busy;  // transmitter busy cycles per byte
    bit         gap;   // idle owner cycle with a stray strobe before each byte
    logic [7:0] ck;    // expected checksum byte
  } vec_t;

  task automatic wait_grant(input logic [NREQ-1:0] exp);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (grant != '0) break;
    end
    check("grant", 32'(grant), 32'(exp));
  endtask

  task automatic load(input int o, input int n, input logic [7:0] d0, input bit gap);
    int other = (o + 1) % NREQ;
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        wr_valid = '0;
        wr_valid[other] = 1'b1;
        wr_data[8*other +: 8] = 8'hEE;
        wr_data[8*o +: 8] = 8'h5A;
        @(posedge clk); #1;
      end
      wr_valid = '0;
      wr_valid[o] = 1'b1;
      wr_valid[other] = gap;
      wr_data[8*o +: 8] = d0 + 8'(i);
      wr_data[8*other +: 8] = 8'hEE;
      @(posedge clk); #1;
    end
    wr_valid = '0;
  endtask

  task automatic wait_done(input int o, input int budget);
    logic [NREQ-1:0] exp = '0;
    exp[o] = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done != '0) break;
    end
    check("done_pulse", 32'(done), 32'(exp));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic check_packet(input logic [7:0] addr, input logic [7:0] len,
                              input logic [7:0] d0, input logic [7:0] ck);
    int n = (len == 8'h00) ? 256 : int'(len);
    int bad = 0;
    check("pkt_size", 32'(rx_q.size()), 32'(3 + n));
    if (rx_q.size() == 3 + n) begin
      check("pkt_ck", 32'(rx_q[0]), 32'(ck));
      check("pkt_addr", 32'(rx_q[1]), 32'(addr));
      check("pkt_len", 32'(rx_q[2]), 32'(len));
      for (int i = 0; i < n; i++) if (rx_q[3+i] !== d0 + 8'(i)) bad++;
      check("pkt_payload_bad_bytes", 32'(bad), 32'd0);
    end
  endtask

  // One whole packet; keep_req leaves req asserted after the grant.
  task automatic do_packet(input int o, input logic [NREQ-1:0] req_mask, input bit keep_req,
                           input logic [7:0] addr, input logic [7:0] len, input logic [7:0] d0,
                           input int bl, input bit gap, input logic [7:0] ck);
    logic [NREQ-1:0] exp = '0;
    int n = (len == 8'h00) ? 256 : int'(len);
    exp[o] = 1'b1;
    rx_q.delete();
    busy_len = bl;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[8*i +: 8] = addr;
      req_len[8*i +: 8]  = len;
    end
    req = req_mask;
    wait_grant(exp);
    if (!keep_req) req = '0;
    load(o, n, d0, gap);
    check("grant_dropped_after_load", 32'(grant), 32'd0);
    check("busy_in_send", 32'(busy), 32'd1);
    wait_done(o, (3 + n) * (bl + 3) + 100);
    check_packet(addr, len, d0, ck);
  endtask

  vec_t vecs [4];

  initial begin
    // addr+len+payload+ck must be 0 mod 256 in every row.
    vecs[0] = '{0, 8'h10, 8'h02, 8'h01, 10,  1'b0, 8'hEB};
    vecs[1] = '{1, 8'h55, 8'h01, 8'hAA, 0,   1'b0, 8'h00};
    vecs[2] = '{0, 8'hFF, 8'h03, 8'h00, 100, 1'b1, 8'hFB};
    vecs[3] = '{1, 8'h01, 8'h04, 8'h10, 3,   1'b1, 8'hB5};
    for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    RESET_N = 1'b1;
    @(posedge clk); #1;

    // Table-driven single-requester packets
    for (int v = 0; v < 4; v++) begin
      logic [NREQ-1:0] m = '0;
      m[vecs[v].owner] = 1'b1;
      do_packet(vecs[v].owner, m, 1'b0, vecs[v].addr, vecs[v].len, vecs[v].d0,
                vecs[v].busy, vecs[v].gap, vecs[v].ck);
      if (v == 0) check("done0_count_first", 32'(done_cnt[0]), 32'd1);
    end

    // Contention: both requests held, rr_ptr is 0 after owner 1 finished
    for (int r = 0; r < 4; r++) begin
      // 0x30+1+0x07 = 0x38 -> ck 0xC8
      do_packet(r % 2, 2'b11, (r < 3), 8'h30, 8'h01, 8'h07, 2, 1'b0, 8'hC8);
    end

    // 256-byte payload: ck = -(0x20 + 0x80) = 0x60
    do_packet(0, 2'b01, 1'b0, 8'h20, 8'h00, 8'h00, 1, 1'b0, 8'h60);

    // Reset mid SEND_DATA (rr_ptr is 1 at this point)
    rx_q.delete();
    busy_len = 20;
    req_addr[15:8] = 8'h33;
    req_len[15:8]  = 8'h08;
    req = 2'b10;
    wait_grant(2'b10);
    req = '0;
    load(1, 8, 8'h40, 1'b0);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rx_q.size() >= 5) break;
    end
    check("reached_send_data", 32'(rx_q.size() >= 5), 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    check("arst_grant", 32'(grant), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_tx_send", 32'(tx_send), 32'd0);
    check("arst_tx_data", 32'(tx_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 RESET_N = 1'b1;
    check("aborted_bytes", 32'(rx_q.size()), 32'd5);
    // Arbitration restarts at rr_ptr=0: 0x44+2+7+8 = 0x55 -> ck 0xAB
    do_packet(0, 2'b11, 1'b0, 8'h44, 8'h02, 8'h07, 20, 1'b0, 8'hAB);

    check("done0_total", 32'(done_cnt[0]), 32'd6);
    check("done1_total", 32'(done_cnt[1]), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
